dvi_timing_gen: RTL and testbench
=================================

# dvi_timing_gen

Raster timing generator for the DVI output path. Walks a configurable horizontal and vertical timing (default 640x480 at 60 Hz, 25.175 MHz pixel clock) and produces registered hsync, vsync, data-enable and pixel coordinates. Sits directly upstream of the three TMDS encoders:
- hsync and vsync drive the blue channel's `c[0]` and `c[1]`.
- den drives `den` on all channels.
- x/y address the pixel source.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of hsync
- V_SYNC_POL, 0, asserted level of vsync
- W_COORD, 12, width of x/y outputs

Every timing parameter is ≥1. Each active dimension is ≤ 2^W_COORD.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; when 0 all state and outputs hold
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- den  out  1  active-video flag
- x  out  W_COORD  active pixel column; 0 when horizontally inactive
- y  out  W_COORD  active line; 0 when vertically inactive
- line_start  out  1  one-cycle pulse with the first pixel-time of each line
- frame_start  out  1  one-cycle pulse with the first pixel-time of each frame
- pix_req  out  1  prefetch request (see Configuration)
- pix_x  out  W_COORD  prefetch column
- pix_y  out  W_COORD  prefetch line

## Operation
- Single clock domain, one clock edge (`clk`). Reset `rst_n` is asynchronous, active-low.
- Horizontal FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Each state lasts its parameter count in enabled cycles.
  - One down-counter per FSM, reloaded on each state transition.
- Vertical FSM: same four states, advanced once per line on the horizontal BACK→ACTIVE transition.
- Line numbering, default parameters:
  - Pixel-times 0–639 ACTIVE, 640–655 FRONT, 656–751 SYNC, 752–799 BACK.
  - Lines 0–479 ACTIVE, 480–489 FRONT, 490–491 SYNC, 492–524 BACK.
- Output decode:
  - hsync = H_SYNC_POL while horizontal state is SYNC, else ~H_SYNC_POL.
  - vsync = V_SYNC_POL for every pixel-time of a line whose vertical state is SYNC, else ~V_SYNC_POL. Edges therefore coincide with line start.
  - den = horizontal ACTIVE and vertical ACTIVE.
  - x counts 0..H_ACTIVE-1 across horizontal ACTIVE.
  - y = line index during vertical ACTIVE.
- After reset the internal state is line 0, pixel-time 0, both FSMs ACTIVE.

## Timing
- All outputs are registered, updated only on enabled edges. Each output reflects the internal position one enabled cycle earlier.
- Reset values:
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
  - den = 0, x = 0, y = 0.
  - line_start = 0, frame_start = 0.
  - pix_req = 0, pix_x = 0, pix_y = 0.
- The first enabled edge after reset release outputs den=1, x=0, y=0, line_start=1, frame_start=1.
- Line period: H_ACTIVE+H_FRONT+H_SYNC+H_BACK enabled cycles. Frame period: line period × (V_ACTIVE+V_FRONT+V_SYNC+V_BACK) lines.
- Wrap-around: the last BACK pixel-time of the last V_BACK line is followed by line 0, pixel 0, with frame_start=1.
- en=0: all state and all outputs hold, including pulses; a pulse held by en=0 stays asserted.
- Reset mid-frame: all outputs return to reset values immediately. Timing then restarts from frame start.

## Configuration
- Macro: `DVI_TIMING_GEN_PREFETCH_EN`.
- Defined:
  - pix_req/pix_x/pix_y equal the den/x/y that will appear one enabled cycle later, including across line and frame wrap.
  - This lets a 1-cycle-latency pixel source (BRAM) align its data with den.
- Undefined: pix_req, pix_x and pix_y are tied to 0. No extra logic.

## Test plan
- Reset release with en=1, default params:
  - Every line has exactly 640 den cycles with x=0..639.
  - hsync low for cycles 656–751 of each line.
  - line_start every 800 cycles; frame_start every 420000 cycles.
- Vertical, default params:
  - vsync low exactly 1600 cycles, starting at line 490 pixel-time 0.
  - y=0..479 during den; den never high on lines 480–524.
- en toggled pseudo-randomly at 50% duty: the output sequence sampled on en=1 edges is identical to the en=1 run.
- rst_n asserted at line 300, pixel 100:
  - Outputs go to reset values asynchronously.
  - After release, frame_start=1 on the first enabled edge.
- Small params (H 4/1/2/1, V 3/1/1/1, both polarities 1):
  - Line = 8 cycles, frame = 48 cycles.
  - hsync high on cycles 5–6.
  - Check wrap and vsync on line 4.
- With `DVI_TIMING_GEN_PREFETCH_EN`: across 2 full frames, pix_req/pix_x/pix_y at cycle n equal den/x/y at the next enabled cycle. Without the macro they remain 0.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen: raster timing generator feeding the TMDS encoders.
// Two cascaded four-state FSMs (horizontal per pixel, vertical per line), each
// with a down-counter reloaded on every state change. All outputs are
// registered and advance only on enabled clock edges.
// Optional feature macro: DVI_TIMING_GEN_PREFETCH_EN. When defined, pix_req,
// pix_x and pix_y present the den/x/y of the following enabled cycle so a
// one-cycle-latency pixel source can line its data up with den.
module dvi_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   W_COORD    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               den,
    output logic [W_COORD-1:0] x,
    output logic [W_COORD-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               pix_req,
    output logic [W_COORD-1:0] pix_x,
    output logic [W_COORD-1:0] pix_y
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width covers the longest state of either FSM (count runs len-1..0).
    localparam int MAX_LEN = max2(max2(max2(H_ACTIVE, H_FRONT), max2(H_SYNC, H_BACK)),
                                  max2(max2(V_ACTIVE, V_FRONT), max2(V_SYNC, V_BACK)));
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } state_t;

    function automatic state_t next_state(input state_t st);
        case (st)
            ST_ACTIVE: return ST_FRONT;
            ST_FRONT:  return ST_SYNC;
            ST_SYNC:   return ST_BACK;
            ST_BACK:   return ST_ACTIVE;
            default:   return ST_ACTIVE;
        endcase
    endfunction

    function automatic logic [CW-1:0] h_load(input state_t st);
        case (st)
            ST_ACTIVE: return CW'(H_ACTIVE - 1);
            ST_FRONT:  return CW'(H_FRONT - 1);
            ST_SYNC:   return CW'(H_SYNC - 1);
            ST_BACK:   return CW'(H_BACK - 1);
            default:   return CW'(H_ACTIVE - 1);
        endcase
    endfunction

    function automatic logic [CW-1:0] v_load(input state_t st);
        case (st)
            ST_ACTIVE: return CW'(V_ACTIVE - 1);
            ST_FRONT:  return CW'(V_FRONT - 1);
            ST_SYNC:   return CW'(V_SYNC - 1);
            ST_BACK:   return CW'(V_BACK - 1);
            default:   return CW'(V_ACTIVE - 1);
        endcase
    endfunction

    // Column within the active region: the down-counter runs H_ACTIVE-1..0.
    function automatic logic [W_COORD-1:0] h_coord(input state_t st, input logic [CW-1:0] cnt);
        if (st == ST_ACTIVE) begin
            return W_COORD'(H_ACTIVE - 1 - int'(cnt));
        end else begin
            return {W_COORD{1'b0}};
        end
    endfunction

    function automatic logic [W_COORD-1:0] v_coord(input state_t st, input logic [CW-1:0] cnt);
        if (st == ST_ACTIVE) begin
            return W_COORD'(V_ACTIVE - 1 - int'(cnt));
        end else begin
            return {W_COORD{1'b0}};
        end
    endfunction

    state_t          h_st_r;
    state_t          v_st_r;
    logic [CW-1:0]   h_cnt_r;
    logic [CW-1:0]   v_cnt_r;
    state_t          h_st_s;
    state_t          v_st_s;
    logic [CW-1:0]   h_cnt_s;
    logic [CW-1:0]   v_cnt_s;
    logic            line_first_s;
    logic            frame_first_s;

    // Next raster position: horizontal steps every cycle, vertical steps at end of BACK.
    always_comb begin
        h_st_s  = h_st_r;
        h_cnt_s = h_cnt_r;
        v_st_s  = v_st_r;
        v_cnt_s = v_cnt_r;
        if (h_cnt_r == {CW{1'b0}}) begin
            h_st_s  = next_state(h_st_r);
            h_cnt_s = h_load(next_state(h_st_r));
            if (h_st_r == ST_BACK) begin
                if (v_cnt_r == {CW{1'b0}}) begin
                    v_st_s  = next_state(v_st_r);
                    v_cnt_s = v_load(next_state(v_st_r));
                end else begin
                    v_cnt_s = v_cnt_r - CW'(1'b1);
                end
            end else begin
                v_st_s  = v_st_r;
                v_cnt_s = v_cnt_r;
            end
        end else begin
            h_cnt_s = h_cnt_r - CW'(1'b1);
        end
    end

    // First pixel-time of a line / of a frame at the current position.
    always_comb begin
        line_first_s  = (h_st_r == ST_ACTIVE) && (h_cnt_r == h_load(ST_ACTIVE));
        frame_first_s = line_first_s && (v_st_r == ST_ACTIVE) && (v_cnt_r == v_load(ST_ACTIVE));
    end

    // Position state and registered decode of the current position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_st_r      <= ST_ACTIVE;
            v_st_r      <= ST_ACTIVE;
            h_cnt_r     <= h_load(ST_ACTIVE);
            v_cnt_r     <= v_load(ST_ACTIVE);
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            den         <= 1'b0;
            x           <= {W_COORD{1'b0}};
            y           <= {W_COORD{1'b0}};
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            h_st_r      <= h_st_s;
            v_st_r      <= v_st_s;
            h_cnt_r     <= h_cnt_s;
            v_cnt_r     <= v_cnt_s;
            hsync       <= (h_st_r == ST_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= (v_st_r == ST_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            den         <= (h_st_r == ST_ACTIVE) && (v_st_r == ST_ACTIVE);
            x           <= h_coord(h_st_r, h_cnt_r);
            y           <= v_coord(v_st_r, v_cnt_r);
            line_start  <= line_first_s;
            frame_start <= frame_first_s;
        end
    end

`ifdef DVI_TIMING_GEN_PREFETCH_EN
    // Prefetch decode of the next position, i.e. the den/x/y one enabled cycle ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req <= 1'b0;
            pix_x   <= {W_COORD{1'b0}};
            pix_y   <= {W_COORD{1'b0}};
        end else if (en) begin
            pix_req <= (h_st_s == ST_ACTIVE) && (v_st_s == ST_ACTIVE);
            pix_x   <= h_coord(h_st_s, h_cnt_s);
            pix_y   <= v_coord(v_st_s, v_cnt_s);
        end
    end
`else
    assign pix_req = 1'b0;
    assign pix_x   = {W_COORD{1'b0}};
    assign pix_y   = {W_COORD{1'b0}};
`endif

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen: a default 640x480 instance and a small
// 4/1/2/1 x 3/1/1/1 instance with both sync polarities high.
module tb_dvi_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        den;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
    } out_t;

    typedef struct {
        int   ha, hf, hs, hb, va, vf, vs, vb;
        logic hp, vp;
    } cfg_t;

`ifdef DVI_TIMING_GEN_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_d, rst_n_s, en_d, en_s;
    logic        d_hsync, d_vsync, d_den, d_ls, d_fs, d_preq;
    logic [11:0] d_x, d_y, d_px, d_py;
    logic        s_hsync, s_vsync, s_den, s_ls, s_fs, s_preq;
    logic [11:0] s_x, s_y, s_px, s_py;

    int vectors = 0;
    int miscompares = 0;

    cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_t cfg_s = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    int   dp, dl, sp, sl;

    always #5 clk = ~clk;

    dvi_timing_gen u_dflt (
        .clk(clk), .rst_n(rst_n_d), .en(en_d),
        .hsync(d_hsync), .vsync(d_vsync), .den(d_den), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs),
        .pix_req(d_preq), .pix_x(d_px), .pix_y(d_py)
    );

    dvi_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .W_COORD(12)
    ) u_small (
        .clk(clk), .rst_n(rst_n_s), .en(en_s),
        .hsync(s_hsync), .vsync(s_vsync), .den(s_den), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs),
        .pix_req(s_preq), .pix_x(s_px), .pix_y(s_py)
    );

    out_t d_obs, s_obs;
    assign d_obs = {d_hsync, d_vsync, d_den, d_x, d_y, d_ls, d_fs};
    assign s_obs = {s_hsync, s_vsync, s_den, s_x, s_y, s_ls, s_fs};

    // Expected outputs for raster position (p, l), from pixel/line arithmetic.
    function automatic out_t model(input cfg_t c, input int p, input int l);
        out_t o;
        o.den = (p < c.ha) && (l < c.va);
        o.x   = (p < c.ha) ? 12'(p) : 12'd0;
        o.y   = (l < c.va) ? 12'(l) : 12'd0;
        o.hs  = (p >= c.ha + c.hf && p < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
        o.vs  = (l >= c.va + c.vf && l < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
        o.ls  = (p == 0);
        o.fs  = (p == 0) && (l == 0);
        return o;
    endfunction

    function automatic void adv(input cfg_t c, inout int p, inout int l);
        p++;
        if (p == c.ha + c.hf + c.hs + c.hb) begin
            p = 0;
            l++;
            if (l == c.va + c.vf + c.vs + c.vb) l = 0;
        end
    endfunction

    function automatic logic [24:0] pf_exp(input out_t n);
        return PF ? {n.den, n.x, n.y} : 25'd0;
    endfunction

    task automatic test_reset();
        rst_n_d = 1'b0; rst_n_s = 1'b0; en_d = 1'b0; en_s = 1'b0;
        #13;
        vectors++;
        if (d_obs !== {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_dflt got=%h exp=%h", d_obs, {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0});
        end
        vectors++;
        if (s_obs !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_small got=%h exp=%h", s_obs, 27'd0);
        end
        vectors++;
        if ({d_preq, d_px, d_py, s_preq, s_px, s_py} !== 50'd0) begin
            miscompares++;
            $display("FAIL reset_pix got=%h exp=0", {d_preq, d_px, d_py, s_preq, s_px, s_py});
        end
        @(negedge clk);
        rst_n_d = 1'b1; rst_n_s = 1'b1;
        dp = 0; dl = 0; sp = 0; sl = 0;
    endtask

    task automatic test_first_edge();
        out_t n;
        @(negedge clk); en_d = 1'b1;
        @(posedge clk); #1;
        adv(cfg_d, dp, dl);
        n = model(cfg_d, dp, dl);
        vectors++;
        if (d_obs !== {1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL first_edge got=%h exp=%h", d_obs, {1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1});
        end
        vectors++;
        if ({d_preq, d_px, d_py} !== pf_exp(n)) begin
            miscompares++;
            $display("FAIL first_edge_pix got=%h exp=%h", {d_preq, d_px, d_py}, pf_exp(n));
        end
    endtask

    task automatic test_default_lines();
        out_t e, n;
        int den_cnt = 0, hs_low = 0, ls_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk); en_d = 1'b1;
            @(posedge clk); #1;
            e = model(cfg_d, dp, dl);
            adv(cfg_d, dp, dl);
            n = model(cfg_d, dp, dl);
            den_cnt += int'(d_den);
            hs_low  += int'(!d_hsync);
            ls_cnt  += int'(d_ls);
            vectors++;
            if (d_obs !== e) begin
                miscompares++;
                $display("FAIL dflt_line cyc=%0d got=%h exp=%h", i, d_obs, e);
            end
            vectors++;
            if ({d_preq, d_px, d_py} !== pf_exp(n)) begin
                miscompares++;
                $display("FAIL dflt_pix cyc=%0d got=%h exp=%h", i, {d_preq, d_px, d_py}, pf_exp(n));
            end
        end
        // Window covers pixel 1 of line 0 through pixel 0 of line 2.
        vectors++;
        if (den_cnt !== 1280) begin
            miscompares++;
            $display("FAIL dflt_den_count got=%0d exp=1280", den_cnt);
        end
        vectors++;
        if (hs_low !== 192) begin
            miscompares++;
            $display("FAIL dflt_hsync_low got=%0d exp=192", hs_low);
        end
        vectors++;
        if (ls_cnt !== 2) begin
            miscompares++;
            $display("FAIL dflt_line_starts got=%0d exp=2", ls_cnt);
        end
    endtask

    task automatic test_hold();
        // Last enabled edge presented line 2 pixel 0, so line_start is high and must stay high.
        out_t held;
        held = {1'b1, 1'b1, 1'b1, 12'd0, 12'd2, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); en_d = 1'b0;
            @(posedge clk); #1;
            vectors++;
            if (d_obs !== held) begin
                miscompares++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", i, d_obs, held);
            end
        end
    endtask

    task automatic test_small_frames();
        out_t e, n;
        logic [7:0] hs_line = 8'd0;
        logic [5:0] vs_lines = 6'd0;
        int fs_cnt = 0;
        logic fs_at48 = 1'b0;
        for (int i = 0; i < 97; i++) begin
            @(negedge clk); en_s = 1'b1;
            @(posedge clk); #1;
            e = model(cfg_s, sp, sl);
            adv(cfg_s, sp, sl);
            n = model(cfg_s, sp, sl);
            if (i < 8) hs_line[i] = s_hsync;
            if (i < 48 && (i % 8) == 0) vs_lines[i / 8] = s_vsync;
            fs_cnt += int'(s_fs);
            if (i == 48) fs_at48 = s_fs;
            vectors++;
            if (s_obs !== e) begin
                miscompares++;
                $display("FAIL small_frame cyc=%0d got=%h exp=%h", i, s_obs, e);
            end
            vectors++;
            if ({s_preq, s_px, s_py} !== pf_exp(n)) begin
                miscompares++;
                $display("FAIL small_pix cyc=%0d got=%h exp=%h", i, {s_preq, s_px, s_py}, pf_exp(n));
            end
        end
        vectors++;
        if (hs_line !== 8'h60) begin
            miscompares++;
            $display("FAIL small_hsync_pattern got=%h exp=60", hs_line);
        end
        vectors++;
        if (vs_lines !== 6'h10) begin
            miscompares++;
            $display("FAIL small_vsync_lines got=%h exp=10", vs_lines);
        end
        vectors++;
        if (fs_cnt !== 3 || fs_at48 !== 1'b1) begin
            miscompares++;
            $display("FAIL small_frame_wrap got=%0d/%b exp=3/1", fs_cnt, fs_at48);
        end
    endtask

    task automatic test_en_toggle();
        out_t e, n;
        logic [24:0] pn;
        e  = model(cfg_s, 0, 0);
        pn = {s_preq, s_px, s_py};
        // Prior test ended with one enabled edge past the wrap; rebuild last expectations.
        e  = model(cfg_s, (sp == 0) ? 7 : sp - 1, (sp == 0) ? ((sl == 0) ? 5 : sl - 1) : sl);
        pn = pf_exp(model(cfg_s, sp, sl));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); en_s = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            if (en_s) begin
                e = model(cfg_s, sp, sl);
                adv(cfg_s, sp, sl);
                n = model(cfg_s, sp, sl);
                pn = pf_exp(n);
            end
            vectors++;
            if (s_obs !== e) begin
                miscompares++;
                $display("FAIL en_toggle cyc=%0d en=%b got=%h exp=%h", i, en_s, s_obs, e);
            end
            vectors++;
            if ({s_preq, s_px, s_py} !== pn) begin
                miscompares++;
                $display("FAIL en_toggle_pix cyc=%0d got=%h exp=%h", i, {s_preq, s_px, s_py}, pn);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (!(sp == 1 && sl == 2) && guard < 100) begin
            @(negedge clk); en_s = 1'b1;
            @(posedge clk); #1;
            adv(cfg_s, sp, sl);
            guard++;
        end
        vectors++;
        if (guard >= 100) begin
            miscompares++;
            $display("FAIL mid_reset_reach got=%0d exp=<100", guard);
        end
        // Outputs now show line 2 pixel 0; assert reset between edges.
        #2 rst_n_s = 1'b0;
        #1;
        vectors++;
        if ({s_obs, s_preq, s_px, s_py} !== 52'd0) begin
            miscompares++;
            $display("FAIL mid_reset_async got=%h exp=0", {s_obs, s_preq, s_px, s_py});
        end
        @(negedge clk); rst_n_s = 1'b1; en_s = 1'b1;
        sp = 0; sl = 0;
        @(posedge clk); #1;
        vectors++;
        if (s_obs !== {1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset_restart got=%h exp=%h", s_obs, {1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_default_lines();
        test_hold();
        test_small_frames();
        test_en_toggle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
